// File: rtl/data_memory_arbiter_pkg.sv
// Shared widths, state encodings and helpers
// for the data memory arbiter.
package data_memory_arbiter_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_WORD  = 64;
  localparam int ARB_PTR_W = 3;
  localparam int ARB_CNT_W = 8;

  typedef enum logic {
    ARB_S_ARB  = 1'b0,
    ARB_S_LOCK = 1'b1
  } arb_state_e;

  typedef logic [ARB_PTR_W-1:0] arb_ptr_t;

  function automatic arb_ptr_t arb_next(
    input arb_ptr_t p,
    input int       n
  );
    return arb_ptr_t'((int'(p) + 1) % n);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first
// requester at or above ptr, wrapping.
module arb_rr_pick
  import data_memory_arbiter_pkg::*;
#(
  parameter int NPORT = 2
) (
  input  logic [NPORT-1:0] req_i,
  input  arb_ptr_t         ptr_i,
  output logic [NPORT-1:0] gnt_o,
  output arb_ptr_t         idx_o
);

  int   sel;
  logic hit;

  always_comb begin
    sel = 0;
    hit = 1'b0;
    // Scan farthest offset first so the
    // closest requester overwrites the rest.
    for (int i = NPORT - 1; i >= 0; i--) begin
      for (int j = 0; j < NPORT; j++) begin
        if (req_i[j] &&
            j == (int'(ptr_i) + i) % NPORT) begin
          sel = j;
          hit = 1'b1;
        end
      end
    end
    gnt_o = '0;
    for (int j = 0; j < NPORT; j++) begin
      gnt_o[j] = hit && (sel == j);
    end
    idx_o = arb_ptr_t'(sel);
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter with lock/timeout in
// front of the single-port data memory.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int NPORT    = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NPORT-1:0]        REQ,
  input  logic [NPORT-1:0]        WE,
  input  logic [NPORT-1:0]        LOCK,
  input  logic [NPORT*DATA_W-1:0] ADDR,
  input  logic [NPORT*DATA_W-1:0] WDATA,
  output logic [NPORT-1:0]        GNT,
  output logic [NPORT-1:0]        RVALID,
  output logic [DATA_W-1:0]       RDATA,
  output logic [DATA_W-1:0]       MEM_ADDR,
  output logic [DATA_W-1:0]       MEM_WDATA,
  output logic                    MEM_WE,
  input  logic [DATA_W-1:0]       MEM_RDATA
);

  arb_state_e             state_q, state_d;
  arb_ptr_t               ptr_q, ptr_d;
  arb_ptr_t               owner_q, owner_d;
  arb_ptr_t               tag_idx_q, tag_idx_d;
  logic                   tag_vld_q, tag_vld_d;
  logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic [NPORT-1:0]       pick_gnt;
  arb_ptr_t               pick_idx;
  logic [NPORT-1:0]       gnt;
  arb_ptr_t               acc_idx;
  logic                   acc;
  logic                   acc_we;
  logic                   acc_lock;
  logic                   timeout;
  logic [DATA_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  arb_rr_pick #(
    .NPORT (NPORT)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    acc_idx = pick_idx;
    if (state_q == ARB_S_LOCK) begin
      acc_idx = owner_q;
      for (int j = 0; j < NPORT; j++) begin
        gnt[j] = REQ[j] &&
                 (owner_q == arb_ptr_t'(j));
      end
    end else begin
      gnt = pick_gnt;
    end
    if (!RST_N) begin
      gnt = '0;
    end
    acc      = |gnt;
    acc_we   = |(gnt & WE);
    acc_lock = |(gnt & LOCK);
    // Idle bus keeps the last accepted payload.
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    for (int j = 0; j < NPORT; j++) begin
      if (gnt[j]) begin
        sel_addr  = ADDR[j*DATA_W +: DATA_W];
        sel_wdata = WDATA[j*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout = (state_q == ARB_S_LOCK) &&
                   (cnt_q == ARB_CNT_W'(LOCK_MAX - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    tag_vld_d = acc && !acc_we;
    tag_idx_d = acc ? acc_idx : tag_idx_q;
    addr_d    = acc ? sel_addr : addr_q;
    wdata_d   = acc ? sel_wdata : wdata_q;
    unique case (state_q)
      ARB_S_ARB: begin
        if (acc) begin
          ptr_d = arb_next(acc_idx, NPORT);
          if (acc_lock) begin
            state_d = ARB_S_LOCK;
            owner_d = acc_idx;
            cnt_d   = '0;
          end
        end
      end
      ARB_S_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        if ((acc && !acc_lock) || timeout) begin
          state_d = ARB_S_ARB;
          ptr_d   = arb_next(owner_q, NPORT);
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ARB_S_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    RVALID = '0;
    for (int j = 0; j < NPORT; j++) begin
      RVALID[j] = RST_N && tag_vld_q &&
                  (tag_idx_q == arb_ptr_t'(j));
    end
  end

  assign GNT       = gnt;
  assign MEM_ADDR  = sel_addr;
  assign MEM_WDATA = sel_wdata;
  assign MEM_WE    = acc_we;
  assign RDATA     = MEM_RDATA;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with
// a behavioural data_memory model.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int NPORT    = 2;
  localparam int LOCK_MAX = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NPORT-1:0]        req = '0;
  logic [NPORT-1:0]        we = '0;
  logic [NPORT-1:0]        lock = '0;
  logic [NPORT*DATA_W-1:0] addr = '0;
  logic [NPORT*DATA_W-1:0] wdata = '0;
  logic [NPORT-1:0]        gnt;
  logic [NPORT-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [DATA_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(
    .NPORT    (NPORT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ       (req),
    .WE        (we),
    .LOCK      (lock),
    .ADDR      (addr),
    .WDATA     (wdata),
    .GNT       (gnt),
    .RVALID    (rvalid),
    .RDATA     (rdata),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_WE    (mem_we),
    .MEM_RDATA (mem_rdata)
  );

  // data_memory: registers inputs, writes one
  // edge later, read port is combinational.
  logic [DATA_W-1:0] mem [MEM_WORD];
  logic [5:0]        ma_r;
  logic [DATA_W-1:0] wd_r;
  logic              we_r = 1'b0;

  always @(posedge clk) begin
    if (we_r) mem[ma_r] <= wd_r;
    ma_r <= mem_addr[5:0];
    wd_r <= mem_wdata;
    we_r <= mem_we;
  end

  assign mem_rdata = mem[ma_r];

  initial begin
    for (int i = 0; i < MEM_WORD; i++) begin
      mem[i] = '0;
    end
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [1:0]  r,
    input logic [1:0]  w,
    input logic [1:0]  l,
    input logic [15:0] a0,
    input logic [15:0] a1,
    input logic [15:0] d0,
    input logic [15:0] d1
  );
    @(negedge clk);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
    #1;
  endtask

  logic [1:0]  cg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [15:0] cd [4] = '{16'h1234, 16'h5678,
                          16'h1234, 16'h5678};

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    drive(2'b11, 2'b11, 2'b00, 16'h3, 16'h4,
          16'h7, 16'h8);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_rv", 32'(rvalid), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wd", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;

    drive(2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t1_gnt", 32'(gnt), 32'h2);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t1_rv", 32'(rvalid), 32'h2);
    chk("t1_rd", 32'(rdata), 32'h1234);

    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 2'b00, 0, 1, 0, 0);
      chk("ct_gnt", 32'(gnt), 32'(cg[i]));
      if (i > 0) begin
        chk("ct_rv", 32'(rvalid), 32'(cg[i-1]));
        chk("ct_rd", 32'(rdata), 32'(cd[i-1]));
      end
    end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("ct_rv", 32'(rvalid), 32'h2);
    chk("ct_rd", 32'(rdata), 32'h5678);

    drive(2'b11, 2'b00, 2'b01, 1, 1, 0, 0);
    chk("lk_gnt0", 32'(gnt), 32'h1);
    drive(2'b11, 2'b01, 2'b00, 1, 1,
          16'hBEEF, 0);
    chk("lk_gnt1", 32'(gnt), 32'h1);
    chk("lk_we", 32'(mem_we), 32'h1);
    chk("lk_rv", 32'(rvalid), 32'h1);
    chk("lk_rd", 32'(rdata), 32'h5678);
    drive(2'b11, 2'b00, 2'b00, 0, 1, 0, 0);
    chk("lk_gnt2", 32'(gnt), 32'h2);
    chk("lk_rvw", 32'(rvalid), 32'h0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("lk_rv1", 32'(rvalid), 32'h2);
    chk("lk_rd1", 32'(rdata), 32'hBEEF);

    drive(2'b01, 2'b00, 2'b01, 0, 0, 0, 0);
    chk("to_gnt0", 32'(gnt), 32'h1);
    for (int k = 1; k <= LOCK_MAX; k++) begin
      drive(2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
      chk("to_wait", 32'(gnt), 32'h0);
      if (k == 1) begin
        chk("to_rv", 32'(rvalid), 32'h1);
        chk("to_rd", 32'(rdata), 32'h1234);
      end
    end
    drive(2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("to_gnt1", 32'(gnt), 32'h2);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("to_rv1", 32'(rvalid), 32'h2);
    chk("to_rd1", 32'(rdata), 32'h1234);

    drive(2'b01, 2'b01, 2'b00, 5, 0,
          16'h00AA, 0);
    chk("rm_gnt", 32'(gnt), 32'h1);
    chk("rm_we", 32'(mem_we), 32'h1);
    chk("rm_wd", 32'(mem_wdata), 32'h00AA);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b11;
    we    = 2'b11;
    #1;
    chk("rm_rgnt", 32'(gnt), 32'h0);
    chk("rm_rwe", 32'(mem_we), 32'h0);
    chk("rm_rrv", 32'(rvalid), 32'h0);
    @(negedge clk);
    #1;
    chk("rm_addr", 32'(mem_addr), 32'h0);
    chk("rm_wd0", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 2'b00, 5, 0, 0, 0);
    chk("rm_gnt1", 32'(gnt), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("rm_rv", 32'(rvalid), 32'h1);
    chk("rm_rd", 32'(rdata), 32'h00AA);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Round-robin arbiter that shares the single-port `data_memory` between `NPORT` requesters, e.g. the CPU load/store stage and a DMA/loader port. It sits directly in front of `data_memory`, driving its `Address`, `WriteData` and `MEMWRITE` inputs. It routes `ReadData` back to the port that issued the read. A LOCK mechanism gives one port exclusive ownership for read-modify-write or burst sequences, with a bounded timeout.

## Interface
- `NPORT`, 2: number of requester ports (2..8).
- `LOCK_MAX`, 16: maximum consecutive cycles in LOCKED before forced release (1..255).
- `CLK`  in  1: single clock, rising edge.
- `RST_N`  in  1: reset, synchronous, active-low.
- `REQ`  in  NPORT: per-port request. Held high with payload stable until granted.
- `WE`  in  NPORT: per-port write enable (1 = write, 0 = read).
- `LOCK`  in  NPORT: per-port lock request, sampled with an accepted transfer.
- `ADDR`  in  NPORT*`DATA_W`: per-port address. Port p occupies bits [p*`DATA_W` +: `DATA_W`].
- `WDATA`  in  NPORT*`DATA_W`: per-port write data, same packing as `ADDR`.
- `GNT`  out  NPORT: one-hot or zero. The transfer is accepted at the edge where `REQ[p]&GNT[p]`.
- `RVALID`  out  NPORT: read data valid for port p.
- `RDATA`  out  `DATA_W`: read data broadcast to all ports; qualified by `RVALID`.
- `MEM_ADDR`  out  `DATA_W`: drives `data_memory` `Address`.
- `MEM_WDATA`  out  `DATA_W`: drives `data_memory` `WriteData`.
- `MEM_WE`  out  1: drives `data_memory` `MEMWRITE`.
- `MEM_RDATA`  in  `DATA_W`: from `data_memory` `ReadData`.

## Operation
- **States.** ARB (free) and LOCKED (owner o).
  - ARB → LOCKED(p): accepted transfer from p with `LOCK[p]`=1.
  - LOCKED → ARB: accepted transfer from o with `LOCK[o]`=0, or the lock counter reaches `LOCK_MAX`.
- **Arbitration in ARB.** Grant the first requesting port found scanning from `ptr` upward, modulo NPORT. After an accepted transfer from p, set `ptr` to (p+1) mod NPORT.
- **Arbitration in LOCKED.** Only o can be granted; other requests wait. `ptr` is frozen. On release, `ptr` is set to (o+1) mod NPORT.
- **Lock counter.**
  - Cleared on entry to LOCKED; increments every cycle in LOCKED.
  - On reaching `LOCK_MAX` the block returns to ARB at the next edge, regardless of o's `REQ`.
  - A transfer by o accepted in that same cycle is still performed.
- **Memory drive.**
  - `MEM_ADDR`/`MEM_WDATA` = selected port's `ADDR`/`WDATA`.
  - `MEM_WE` = `WE` of the granted port while a grant is active, else 0.
  - With no grant, `MEM_ADDR`/`MEM_WDATA` hold the last granted port's values; `MEM_WE`=0.
- **Read return.**
  - A registered tag (valid bit + port index) records each accepted read.
  - `RVALID[tag]` = 1 in the following cycle; `RDATA` = `MEM_RDATA` combinationally.
  - Writes produce no `RVALID`; `GNT` is their acknowledge.
- At most one transfer is accepted per cycle. Back-to-back transfers are allowed every cycle, including from different ports.

## Timing
- `GNT` is combinational from `REQ`, state and `ptr` in the same cycle.
- Transfer accepted at edge N: `data_memory` registers address/data at N.
  - Read: `RVALID`/`RDATA` valid during cycle N+1, sampled at edge N+1.
  - Write: memory array updated at edge N+1.
- Write at N then read of the same address at N+1 returns the new data in cycle N+2.
- **Reset (`RST_N`=0 at an edge):**
  - Next state ARB; `ptr`=0; lock counter = 0; tag valid = 0.
  - While `RST_N` is low: `GNT`=0, `MEM_WE`=0, `RVALID`=0.
  - `MEM_ADDR`=0 and `MEM_WDATA`=0 from the first reset edge.
- **Reset mid-operation.**
  - A write accepted at the edge before reset still commits, because `data_memory` is not reset.
  - A read accepted at that edge gets no `RVALID`.
- Simultaneous requests in ARB: strict rotation; no port waits more than NPORT-1 grants.

## Structure
- Existing `def.v` supplies `DATA_W` and `MEM_WORD`.
- Add `ARB_S_ARB` and `ARB_S_LOCK` state encodings and the `ARB_PTR_W` width macro to `def.v`.
- Sub-module `arb_rr_pick`: combinational round-robin picker. Inputs `REQ` and `ptr`; outputs a one-hot grant and the encoded index. All state stays in `data_memory_arbiter`.

## Test plan
- **Single read after reset.** Port 1 reads address 0 → `GNT`=2'b10 immediately; `RVALID[1]`=1 with `RDATA`=16'h1234 the next cycle; `RVALID[0]`=0.
- **Contention.** Both ports request reads of addresses 0 and 1 every cycle → grants alternate 0,1,0,1. `RDATA` alternates 16'h1234/16'h5678 with matching `RVALID` bits.
- **Lock.** Port 0 does read addr 1 with LOCK=1, then write 16'hBEEF with LOCK=0. Port 1 requests throughout → port 1 is blocked for both transfers and granted the cycle after release. Port 1 reading addr 1 returns 16'hBEEF.
- **Lock timeout.** Port 0 locks, then drops `REQ` → exactly `LOCK_MAX` cycles later port 1 is granted.
- **Reset mid-operation.** Port 0 writes 16'h00AA to addr 5; `RST_N`=0 on the following edge → `GNT`/`RVALID`/`MEM_WE` are 0 during reset. After reset, a read of addr 5 returns 16'h00AA.
